// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial IF/LS controller for the 8-bit RAM/IO port, little-endian assembly.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority.
module mem_arbiter #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  state_t      state;
  owner_t      owner;
  logic [31:0] base, wdata, asm_q, cur_addr, rd_word;
  logic [2:0]  len, k;
  logic [1:0]  cap_idx;
  logic        if_ok, grant_if, grant_ls, stall;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A flush in IDLE withholds the IF grant for that cycle only.
  assign if_ok = if_req && !flush;
`ifdef MEM_ARB_RR_EN
  owner_t last_grant;
  assign grant_ls = ls_req && (!if_ok || last_grant == OWN_IF);
`else
  assign grant_ls = ls_req;
`endif
  assign grant_if = if_ok && !grant_ls;

  assign cur_addr = base + {29'd0, k};
  assign cap_idx  = k[1:0] - 2'd1;
  assign stall    = (state == WRITE) && io_buffer_full && (cur_addr[17:16] == IO_SEL);

  // Port drive decodes the registered state directly, so reset clears it at once.
  assign mem_a    = ((state == READ && k < len) || state == WRITE) ? cur_addr : 32'd0;
  assign mem_wr   = (state == WRITE) && !stall;
  assign mem_dout = (state == WRITE) ? wdata[{k[1:0], 3'b000} +: 8] : 8'd0;

  // Byte k-1 arrives on mem_din while address k is (or would be) on the bus.
  // NOTE: default first, so every path assigns rd_word and no latch is inferred.
  always_comb begin
    rd_word = asm_q;
    if (k != 3'd0) rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      base     <= '0;
      wdata    <= '0;
      asm_q    <= '0;
      len      <= '0;
      k        <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= OWN_IF;
`endif
    end else begin
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
      case (state)
        IDLE: begin
          if (grant_ls) begin
            owner <= OWN_LS;
            base  <= ls_addr;
            wdata <= ls_wdata;
            len   <= size_len(ls_size);
            k     <= '0;
            asm_q <= '0;
            state <= ls_we ? WRITE : READ;
`ifdef MEM_ARB_RR_EN
            last_grant <= OWN_LS;
`endif
          end else if (grant_if) begin
            owner <= OWN_IF;
            base  <= if_addr;
            wdata <= '0;
            len   <= 3'd4;
            k     <= '0;
            asm_q <= '0;
            state <= READ;
`ifdef MEM_ARB_RR_EN
            last_grant <= OWN_IF;
`endif
          end
        end
        READ: begin
          if (flush && owner == OWN_IF) begin
            state <= IDLE;
          end else begin
            asm_q <= rd_word;
            if (k == len) begin
              state <= DONE;
              if (owner == OWN_IF) begin
                if_done <= 1'b1;
                if_data <= rd_word;
              end else begin
                ls_done  <= 1'b1;
                ls_rdata <= rd_word;
              end
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        WRITE: begin
          if (!stall) begin
            if (k == len - 3'd1) begin
              state   <= DONE;
              ls_done <= 1'b1;
            end else begin
              k <= k + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
